// File: rtl/hs_merge_arbiter_pkg.sv
// Shared types and helpers for the two-phase handshake merge arbiter.
// rr_pick is sized for the largest supported channel count (8).
package hs_merge_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } hs_state_e;

  localparam int SYNC_STAGES_DEF = 2;

  // Next pending index after last, wrapping modulo n_ch; returns last when nothing is pending.
  function automatic logic [2:0] rr_pick(input logic [7:0] pending,
                                         input logic [2:0] last,
                                         input logic [3:0] n_ch);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    idx   = last;
    pick  = last;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ({1'b0, idx} == (n_ch - 4'd1)) begin
        idx = 3'd0;
      end else begin
        idx = idx + 3'd1;
      end
      if (!found && (i < int'(n_ch)) && pending[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/hs_merge_arbiter_if.sv
// Bundle of the N-channel toggle handshake inputs and the merged output channel.
// slave is the arbiter's view; master is the requester/sink environment's view.
interface hs_merge_arbiter_if #(
  parameter int N_CH = 3,
  parameter int DW   = 8
);
  localparam int GW = $clog2(N_CH);

  logic [N_CH-1:0]    in_req;
  logic [N_CH-1:0]    in_ack;
  logic [N_CH*DW-1:0] in_data;
  logic               out_req;
  logic               out_ack;
  logic [DW-1:0]      out_data;
  logic [GW-1:0]      grant_idx;
  logic               busy;

  modport master (
    output in_req, in_data, out_ack,
    input  in_ack, out_req, out_data, grant_idx, busy
  );

  modport slave (
    input  in_req, in_data, out_ack,
    output in_ack, out_req, out_data, grant_idx, busy
  );

endinterface

// File: rtl/hs_merge_arbiter_sync.sv
// W-bit multi-flop synchroniser for toggle signals arriving asynchronously to clk.
module hs_merge_arbiter_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] sync_out
);

  logic [W-1:0] stage_r [STAGES];

  // Shift chain; stage 0 is the only flop that may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= async_in;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign sync_out = stage_r[STAGES-1];

endmodule

// File: rtl/hs_merge_arbiter.sv
// Round-robin merge of N two-phase bundled-data channels onto one two-phase output.
// One transfer in flight at a time; all outputs are registered.
module hs_merge_arbiter
  import hs_merge_arbiter_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int DW          = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  hs_merge_arbiter_if.slave  bus
);

  localparam int GW = $clog2(N_CH);

  logic [N_CH-1:0] req_s;
  logic            ack_s;
  logic [N_CH-1:0] pending_s;
  logic [7:0]      pend8_s;
  logic [2:0]      pick_s;
  logic [GW-1:0]   winner_s;
  logic            grant_en_s;
  logic            done_s;

  hs_state_e       state_r;
  hs_state_e       state_nxt_s;
  logic [N_CH-1:0] in_ack_r;
  logic            out_req_r;
  logic [DW-1:0]   out_data_r;
  logic [GW-1:0]   grant_idx_r;
  logic [GW-1:0]   last_grant_r;
  logic            busy_r;

  hs_merge_arbiter_sync #(.W(N_CH), .STAGES(SYNC_STAGES)) u_req_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.in_req),
    .sync_out (req_s)
  );

  hs_merge_arbiter_sync #(.W(1), .STAGES(SYNC_STAGES)) u_ack_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.out_ack),
    .sync_out (ack_s)
  );

  assign pending_s = req_s ^ in_ack_r;

  // Widen pending vector to the fixed width the round-robin helper expects.
  always_comb begin
    pend8_s               = 8'h00;
    pend8_s[N_CH-1:0]     = pending_s;
  end

  assign pick_s   = rr_pick(pend8_s, 3'(last_grant_r), 4'(N_CH));
  assign winner_s = GW'(pick_s);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; the downstream has acked once its phase matches out_req again.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (|pending_s) state_nxt_s = WAIT;
        else            state_nxt_s = IDLE;
      end
      WAIT: begin
        if (ack_s == out_req_r) state_nxt_s = IDLE;
        else                    state_nxt_s = WAIT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode: grant strobe in IDLE, completion strobe in WAIT.
  always_comb begin
    grant_en_s = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (|pending_s) grant_en_s = 1'b1;
        else            grant_en_s = 1'b0;
      end
      WAIT: begin
        if (ack_s == out_req_r) done_s = 1'b1;
        else                    done_s = 1'b0;
      end
      default: begin
        grant_en_s = 1'b0;
        done_s     = 1'b0;
      end
    endcase
  end

  // Datapath: data latch, phase toggles and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ack_r     <= '0;
      out_req_r    <= 1'b0;
      out_data_r   <= '0;
      grant_idx_r  <= '0;
      last_grant_r <= GW'(N_CH - 1);
      busy_r       <= 1'b0;
    end else if (grant_en_s) begin
      out_data_r  <= bus.in_data[winner_s*DW +: DW];
      grant_idx_r <= winner_s;
      out_req_r   <= ~out_req_r;
      busy_r      <= 1'b1;
    end else if (done_s) begin
      in_ack_r[grant_idx_r] <= ~in_ack_r[grant_idx_r];
      last_grant_r          <= grant_idx_r;
      busy_r                <= 1'b0;
    end else begin
      busy_r <= busy_r;
    end
  end

  assign bus.in_ack    = in_ack_r;
  assign bus.out_req   = out_req_r;
  assign bus.out_data  = out_data_r;
  assign bus.grant_idx = grant_idx_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_hs_merge_arbiter.sv
// Directed self-checking bench for hs_merge_arbiter: a 3x8 instance and a 2x16 instance.
module tb_hs_merge_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hs_merge_arbiter_if #(.N_CH(3), .DW(8))  bus3 ();
  hs_merge_arbiter_if #(.N_CH(2), .DW(16)) bus2 ();

  hs_merge_arbiter #(.N_CH(3), .DW(8), .SYNC_STAGES(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  hs_merge_arbiter #(.N_CH(2), .DW(16), .SYNC_STAGES(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  task automatic apply_reset();
    rst_n = 1'b0;
    bus3.in_req = 3'b000; bus3.out_ack = 1'b0; bus3.in_data = 24'h000000;
    bus2.in_req = 2'b00;  bus2.out_ack = 1'b0; bus2.in_data = 32'h00000000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_out_req(output int cycles);
    logic prev;
    prev   = bus3.out_req;
    cycles = 999;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus3.out_req !== prev) begin cycles = i; break; end
    end
  endtask

  task automatic wait_in_ack(input int ch, output int cycles);
    logic prev;
    prev   = bus3.in_ack[ch];
    cycles = 999;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus3.in_ack[ch] !== prev) begin cycles = i; break; end
    end
  endtask

  task automatic wait2_out_req(output int cycles);
    logic prev;
    prev   = bus2.out_req;
    cycles = 999;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus2.out_req !== prev) begin cycles = i; break; end
    end
  endtask

  task automatic wait2_in_ack(input int ch, output int cycles);
    logic prev;
    prev   = bus2.in_ack[ch];
    cycles = 999;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus2.in_ack[ch] !== prev) begin cycles = i; break; end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(posedge clk); #1;
    n_cmp++; if (bus3.in_ack !== 3'b000) begin n_fail++; $display("FAIL reset_in_ack got %b want 000", bus3.in_ack); end
    n_cmp++; if (bus3.out_req !== 1'b0) begin n_fail++; $display("FAIL reset_out_req got %b want 0", bus3.out_req); end
    n_cmp++; if (bus3.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", bus3.out_data); end
    n_cmp++; if (bus3.grant_idx !== 2'd0) begin n_fail++; $display("FAIL reset_grant got %0d want 0", bus3.grant_idx); end
    n_cmp++; if (bus3.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus3.busy); end
  endtask

  task automatic test_single();
    int cyc;
    // rising phase
    @(negedge clk); bus3.in_data[7:0] = 8'hA5; bus3.in_req[0] = 1'b1;
    wait_out_req(cyc);
    n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL single_rise_req_lat got %0d want 3", cyc); end
    n_cmp++; if (bus3.out_req !== 1'b1) begin n_fail++; $display("FAIL single_rise_out_req got %b want 1", bus3.out_req); end
    n_cmp++; if (bus3.out_data !== 8'hA5) begin n_fail++; $display("FAIL single_rise_data got %h want a5", bus3.out_data); end
    n_cmp++; if (bus3.busy !== 1'b1) begin n_fail++; $display("FAIL single_rise_busy got %b want 1", bus3.busy); end
    @(negedge clk); bus3.out_ack = 1'b1;
    wait_in_ack(0, cyc);
    n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL single_rise_ack_lat got %0d want 3", cyc); end
    n_cmp++; if (bus3.in_ack !== 3'b001) begin n_fail++; $display("FAIL single_rise_in_ack got %b want 001", bus3.in_ack); end
    n_cmp++; if (bus3.busy !== 1'b0) begin n_fail++; $display("FAIL single_rise_idle got %b want 0", bus3.busy); end
    // falling phase
    @(negedge clk); bus3.in_data[7:0] = 8'h5A; bus3.in_req[0] = 1'b0;
    wait_out_req(cyc);
    n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL single_fall_req_lat got %0d want 3", cyc); end
    n_cmp++; if (bus3.out_req !== 1'b0) begin n_fail++; $display("FAIL single_fall_out_req got %b want 0", bus3.out_req); end
    n_cmp++; if (bus3.out_data !== 8'h5A) begin n_fail++; $display("FAIL single_fall_data got %h want 5a", bus3.out_data); end
    @(negedge clk); bus3.out_ack = 1'b0;
    wait_in_ack(0, cyc);
    n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL single_fall_ack_lat got %0d want 3", cyc); end
    n_cmp++; if (bus3.in_ack !== 3'b000) begin n_fail++; $display("FAIL single_fall_in_ack got %b want 000", bus3.in_ack); end
  endtask

  task automatic test_simultaneous();
    int cyc;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    apply_reset();
    @(negedge clk); bus3.in_data = 24'h332211; bus3.in_req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      wait_out_req(cyc);
      n_cmp++; if (cyc > 100) begin n_fail++; $display("FAIL simul_timeout[%0d] got %0d want <=100", k, cyc); end
      n_cmp++; if (bus3.grant_idx !== 2'(k)) begin n_fail++; $display("FAIL simul_grant[%0d] got %0d want %0d", k, bus3.grant_idx, k); end
      n_cmp++; if (bus3.out_data !== exp_d[k]) begin n_fail++; $display("FAIL simul_data[%0d] got %h want %h", k, bus3.out_data, exp_d[k]); end
      @(negedge clk); bus3.out_ack = ~bus3.out_ack;
      wait_in_ack(k, cyc);
      n_cmp++; if (bus3.in_ack[k] !== 1'b1) begin n_fail++; $display("FAIL simul_ack[%0d] got %b want 1", k, bus3.in_ack[k]); end
    end
  endtask

  task automatic test_fairness();
    int cyc;
    logic [1:0] exp_g [3];
    logic [7:0] exp_d [3];
    exp_g[0] = 2'd0; exp_g[1] = 2'd2; exp_g[2] = 2'd0;
    exp_d[0] = 8'h44; exp_d[1] = 8'h55; exp_d[2] = 8'h4C;
    @(negedge clk);
    bus3.in_data[7:0] = 8'h44; bus3.in_data[23:16] = 8'h55;
    bus3.in_req[0] = ~bus3.in_req[0]; bus3.in_req[2] = ~bus3.in_req[2];
    for (int k = 0; k < 3; k++) begin
      wait_out_req(cyc);
      n_cmp++; if (bus3.grant_idx !== exp_g[k]) begin n_fail++; $display("FAIL fair_grant[%0d] got %0d want %0d", k, bus3.grant_idx, exp_g[k]); end
      n_cmp++; if (bus3.out_data !== exp_d[k]) begin n_fail++; $display("FAIL fair_data[%0d] got %h want %h", k, bus3.out_data, exp_d[k]); end
      @(negedge clk); bus3.out_ack = ~bus3.out_ack;
      wait_in_ack(int'(exp_g[k]), cyc);
      if (k == 0) begin
        @(negedge clk); bus3.in_data[7:0] = 8'h4C; bus3.in_req[0] = ~bus3.in_req[0];
      end
    end
  endtask

  task automatic test_stall();
    int cyc;
    logic [12:0] held;
    @(negedge clk); bus3.in_data[7:0] = 8'h66; bus3.in_req[0] = ~bus3.in_req[0];
    wait_out_req(cyc);
    n_cmp++; if (bus3.grant_idx !== 2'd0) begin n_fail++; $display("FAIL stall_first_grant got %0d want 0", bus3.grant_idx); end
    held = {bus3.out_req, 8'h66, 1'b1, bus3.in_ack};
    for (int i = 0; i < 50; i++) begin
      if (i == 5) begin
        @(negedge clk); bus3.in_data[15:8] = 8'h77; bus3.in_req[1] = ~bus3.in_req[1];
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({bus3.out_req, bus3.out_data, bus3.busy, bus3.in_ack} !== held) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got %h want %h", i, {bus3.out_req, bus3.out_data, bus3.busy, bus3.in_ack}, held);
      end
    end
    @(negedge clk); bus3.out_ack = ~bus3.out_ack;
    wait_in_ack(0, cyc);
    n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL stall_release_lat got %0d want 3", cyc); end
    wait_out_req(cyc);
    n_cmp++; if (cyc > 2) begin n_fail++; $display("FAIL stall_next_grant_lat got %0d want <=2", cyc); end
    n_cmp++; if (bus3.grant_idx !== 2'd1) begin n_fail++; $display("FAIL stall_next_grant got %0d want 1", bus3.grant_idx); end
    n_cmp++; if (bus3.out_data !== 8'h77) begin n_fail++; $display("FAIL stall_next_data got %h want 77", bus3.out_data); end
    @(negedge clk); bus3.out_ack = ~bus3.out_ack;
    wait_in_ack(1, cyc);
    n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL stall_ch1_ack_lat got %0d want 3", cyc); end
  endtask

  task automatic test_reset_wait();
    int cyc;
    @(negedge clk); bus3.in_data[23:16] = 8'h99; bus3.in_req[2] = ~bus3.in_req[2];
    wait_out_req(cyc);
    n_cmp++; if (bus3.busy !== 1'b1) begin n_fail++; $display("FAIL rstw_busy_before got %b want 1", bus3.busy); end
    #2;
    rst_n = 1'b0;
    bus3.in_req = 3'b000; bus3.out_ack = 1'b0;
    #1;
    n_cmp++; if (bus3.in_ack !== 3'b000) begin n_fail++; $display("FAIL rstw_in_ack got %b want 000", bus3.in_ack); end
    n_cmp++; if (bus3.out_req !== 1'b0) begin n_fail++; $display("FAIL rstw_out_req got %b want 0", bus3.out_req); end
    n_cmp++; if (bus3.out_data !== 8'h00) begin n_fail++; $display("FAIL rstw_out_data got %h want 00", bus3.out_data); end
    n_cmp++; if (bus3.grant_idx !== 2'd0) begin n_fail++; $display("FAIL rstw_grant got %0d want 0", bus3.grant_idx); end
    n_cmp++; if (bus3.busy !== 1'b0) begin n_fail++; $display("FAIL rstw_busy got %b want 0", bus3.busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus3.out_req, bus3.busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL rstw_quiet[%0d] got %b want 00", i, {bus3.out_req, bus3.busy});
      end
    end
  endtask

  task automatic test_n2();
    int cyc;
    @(negedge clk); bus2.in_data[31:16] = 16'hBEEF; bus2.in_req[1] = 1'b1;
    wait2_out_req(cyc);
    n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL n2_lat got %0d want 3", cyc); end
    n_cmp++; if (bus2.grant_idx !== 1'b1) begin n_fail++; $display("FAIL n2_grant1 got %0d want 1", bus2.grant_idx); end
    n_cmp++; if (bus2.out_data !== 16'hBEEF) begin n_fail++; $display("FAIL n2_data1 got %h want beef", bus2.out_data); end
    @(negedge clk); bus2.out_ack = ~bus2.out_ack;
    wait2_in_ack(1, cyc);
    n_cmp++; if (bus2.in_ack !== 2'b10) begin n_fail++; $display("FAIL n2_ack1 got %b want 10", bus2.in_ack); end
    // both pending with pointer at 1: search wraps to 0 first
    @(negedge clk);
    bus2.in_data = {16'hCAFE, 16'h1234};
    bus2.in_req  = ~bus2.in_req;
    wait2_out_req(cyc);
    n_cmp++; if (bus2.grant_idx !== 1'b0) begin n_fail++; $display("FAIL n2_wrap_grant got %0d want 0", bus2.grant_idx); end
    n_cmp++; if (bus2.out_data !== 16'h1234) begin n_fail++; $display("FAIL n2_wrap_data got %h want 1234", bus2.out_data); end
    @(negedge clk); bus2.out_ack = ~bus2.out_ack;
    wait2_in_ack(0, cyc);
    wait2_out_req(cyc);
    n_cmp++; if (bus2.grant_idx !== 1'b1) begin n_fail++; $display("FAIL n2_second_grant got %0d want 1", bus2.grant_idx); end
    n_cmp++; if (bus2.out_data !== 16'hCAFE) begin n_fail++; $display("FAIL n2_second_data got %h want cafe", bus2.out_data); end
    @(negedge clk); bus2.out_ack = ~bus2.out_ack;
    wait2_in_ack(1, cyc);
    n_cmp++; if (bus2.in_ack !== 2'b01) begin n_fail++; $display("FAIL n2_final_ack got %b want 01", bus2.in_ack); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_stall();
    test_reset_wait();
    test_n2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
